reg_operand_stage: RTL and testbench

Dispatch-side operand read and scoreboard stage for the OoO RV32IMC core. It sits directly upstream of execution and beside the register file. It tracks which architectural registers have an outstanding producer, stalls RAW/WAW hazards, and reads source operands from the register file's flattened 1024-bit read bus. Operands are bypassed from the four writeback ports (jump, mem, int0, int1) in the cycle they retire, and the instruction is handed to execution through a registered valid/ready stage.

---
 rtl/reg_operand_stage.sv | 140 ++++++++++++++
 tb/tb_reg_operand_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_operand_stage.sv
// Dispatch operand read, register scoreboard and RAW/WAW stall stage.
// Define SCOREBOARD_BYPASS_EN to resolve hazards from same-cycle writebacks.
module reg_operand_stage #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic [31:0]        id_pc_i,
    input  logic [4:0]         id_rs1_i,
    input  logic [4:0]         id_rs2_i,
    input  logic               id_rs1_en_i,
    input  logic               id_rs2_en_i,
    input  logic [4:0]         id_rd_i,
    input  logic               id_rd_we_i,
    input  logic [NREG*XLEN-1:0] reg_rdata_i,
    input  logic               we_jump_0_i,
    input  logic [4:0]         waddr_jump_0_i,
    input  logic [XLEN-1:0]    wdata_jump_0_i,
    input  logic               we_mem_0_i,
    input  logic [4:0]         waddr_mem_0_i,
    input  logic [XLEN-1:0]    wdata_mem_0_i,
    input  logic               we_int_0_i,
    input  logic [4:0]         waddr_int_0_i,
    input  logic [XLEN-1:0]    wdata_int_0_i,
    input  logic               we_int_1_i,
    input  logic [4:0]         waddr_int_1_i,
    input  logic [XLEN-1:0]    wdata_int_1_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [31:0]        ex_pc_o,
    output logic [XLEN-1:0]    ex_rs1_data_o,
    output logic [XLEN-1:0]    ex_rs2_data_o,
    output logic [4:0]         ex_rd_o,
    output logic               ex_rd_we_o
);

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] set_mask;
    logic            raw1;
    logic            raw2;
    logic            waw;
    logic            accept;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // Registers being written back this cycle; x0 never counts.
    always_comb begin
        wb_hit = '0;
        if (we_jump_0_i) wb_hit[waddr_jump_0_i] = 1'b1;
        if (we_mem_0_i)  wb_hit[waddr_mem_0_i]  = 1'b1;
        if (we_int_0_i)  wb_hit[waddr_int_0_i]  = 1'b1;
        if (we_int_1_i)  wb_hit[waddr_int_1_i]  = 1'b1;
        wb_hit[0] = 1'b0;
    end

    function automatic logic [XLEN-1:0] operand(
        input logic [4:0] rs,
        input logic       en
    );
        logic [XLEN-1:0] v;
        v = reg_rdata_i[int'(rs)*XLEN +: XLEN];
        if (!en || rs == 5'd0) begin
            v = '0;
        end else if (BYPASS && wb_hit[rs]) begin
            if (we_jump_0_i && waddr_jump_0_i == rs)
                v = wdata_jump_0_i;
            else if (we_mem_0_i && waddr_mem_0_i == rs)
                v = wdata_mem_0_i;
            else if (we_int_0_i && waddr_int_0_i == rs)
                v = wdata_int_0_i;
            else
                v = wdata_int_1_i;
        end
        return v;
    endfunction

    assign rs1_data = operand(id_rs1_i, id_rs1_en_i);
    assign rs2_data = operand(id_rs2_i, id_rs2_en_i);

    assign raw1 = id_rs1_en_i && id_rs1_i != 5'd0
               && busy[id_rs1_i]
               && !(BYPASS && wb_hit[id_rs1_i]);
    assign raw2 = id_rs2_en_i && id_rs2_i != 5'd0
               && busy[id_rs2_i]
               && !(BYPASS && wb_hit[id_rs2_i]);
    assign waw  = id_rd_we_i && id_rd_i != 5'd0
               && busy[id_rd_i]
               && !(BYPASS && wb_hit[id_rd_i]);

    assign id_ready_o = !flush_i
                     && (!ex_valid_o || ex_ready_i)
                     && !raw1 && !raw2 && !waw;
    assign accept = id_valid_i && id_ready_o;

    always_comb begin
        set_mask = '0;
        if (accept && id_rd_we_i) set_mask[id_rd_i] = 1'b1;
        set_mask[0] = 1'b0;
    end

    // Set is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst || flush_i) busy <= '0;
        else                busy <= (busy & ~wb_hit) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_rd_o       <= '0;
            ex_rd_we_o    <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (accept) begin
            ex_valid_o    <= 1'b1;
            ex_pc_o       <= id_pc_i;
            ex_rs1_data_o <= rs1_data;
            ex_rs2_data_o <= rs2_data;
            ex_rd_o       <= id_rd_i;
            ex_rd_we_o    <= id_rd_we_i;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_operand_stage.sv
// Randomized bench for reg_operand_stage against a register-level model.
// Follows SCOREBOARD_BYPASS_EN the same way the design does.
module tb_reg_operand_stage;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, flush_i, id_valid_i, id_ready_o;
    logic [31:0] id_pc_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic id_rs1_en_i, id_rs2_en_i, id_rd_we_i;
    logic [1023:0] reg_rdata_i;
    logic ex_valid_o, ex_ready_i, ex_rd_we_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o;
    logic [4:0] ex_rd_o;

    // Writeback ports in priority order: jump, mem, int0, int1.
    logic        wb_we   [4];
    logic [4:0]  wb_addr [4];
    logic [31:0] wb_data [4];

    logic [31:0] rf [32];
    logic [31:0] mbusy;
    bit          m_valid;
    logic [31:0] m_pc, m_a, m_b;
    logic [4:0]  m_rd;
    bit          m_we;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 32; i++) reg_rdata_i[i*32 +: 32] = rf[i];
    end

    reg_operand_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_pc_i(id_pc_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_en_i(id_rs1_en_i), .id_rs2_en_i(id_rs2_en_i),
        .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
        .reg_rdata_i(reg_rdata_i),
        .we_jump_0_i(wb_we[0]), .waddr_jump_0_i(wb_addr[0]),
        .wdata_jump_0_i(wb_data[0]),
        .we_mem_0_i(wb_we[1]), .waddr_mem_0_i(wb_addr[1]),
        .wdata_mem_0_i(wb_data[1]),
        .we_int_0_i(wb_we[2]), .waddr_int_0_i(wb_addr[2]),
        .wdata_int_0_i(wb_data[2]),
        .we_int_1_i(wb_we[3]), .waddr_int_1_i(wb_addr[3]),
        .wdata_int_1_i(wb_data[3]),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit written(input logic [4:0] r);
        for (int p = 0; p < 4; p++)
            if (wb_we[p] && wb_addr[p] == r && r != 5'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] wb_value(input logic [4:0] r);
        for (int p = 0; p < 4; p++)
            if (wb_we[p] && wb_addr[p] == r) return wb_data[p];
        return 32'h0;
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r, input bit en);
        if (!en || r == 5'd0) return 32'h0;
        if (BYP && written(r)) return wb_value(r);
        return rf[r];
    endfunction

    function automatic bit blocked(input logic [4:0] r, input bit en);
        return en && r != 5'd0 && mbusy[r] && !(BYP && written(r));
    endfunction

    function automatic bit exp_ready();
        bit haz;
        haz = blocked(id_rs1_i, id_rs1_en_i)
           || blocked(id_rs2_i, id_rs2_en_i)
           || blocked(id_rd_i, id_rd_we_i);
        return !flush_i && (!m_valid || ex_ready_i) && !haz;
    endfunction

    task automatic step();
        bit rdy, acc;
        logic [31:0] na, nb;
        #1;
        rdy = exp_ready();
        if (!rst) check("id_ready", {31'b0, id_ready_o}, {31'b0, rdy});
        acc = id_valid_i && rdy;
        na = opnd(id_rs1_i, id_rs1_en_i);
        nb = opnd(id_rs2_i, id_rs2_en_i);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_rd = 0; m_we = 0;
            mbusy = 0;
        end else if (flush_i) begin
            m_valid = 0;
            mbusy = 0;
        end else begin
            for (int p = 0; p < 4; p++)
                if (wb_we[p]) mbusy[wb_addr[p]] = 1'b0;
            if (acc && id_rd_we_i && id_rd_i != 5'd0)
                mbusy[id_rd_i] = 1'b1;
            if (acc) begin
                m_valid = 1; m_pc = id_pc_i; m_a = na; m_b = nb;
                m_rd = id_rd_i; m_we = id_rd_we_i;
            end else if (ex_ready_i) begin
                m_valid = 0;
            end
        end
        mbusy[0] = 1'b0;
        for (int p = 3; p >= 0; p--)
            if (wb_we[p] && wb_addr[p] != 5'd0) rf[wb_addr[p]] = wb_data[p];
        if (!rst) begin
            check("ex_valid", {31'b0, ex_valid_o}, {31'b0, m_valid});
            check("busy", dut.busy, mbusy);
            if (m_valid) begin
                check("ex_pc", ex_pc_o, m_pc);
                check("ex_rs1", ex_rs1_data_o, m_a);
                check("ex_rs2", ex_rs2_data_o, m_b);
                check("ex_rd", {27'b0, ex_rd_o}, {27'b0, m_rd});
                check("ex_rd_we", {31'b0, ex_rd_we_o}, {31'b0, m_we});
            end
        end
    endtask

    task automatic idle();
        flush_i = 0; id_valid_i = 0; id_pc_i = 0;
        id_rs1_i = 0; id_rs2_i = 0; id_rs1_en_i = 0; id_rs2_en_i = 0;
        id_rd_i = 0; id_rd_we_i = 0; ex_ready_i = 1;
        for (int p = 0; p < 4; p++) begin
            wb_we[p] = 0; wb_addr[p] = 0; wb_data[p] = 0;
        end
    endtask

    task automatic rand_stim();
        id_valid_i = $urandom_range(0, 3) != 0;
        id_pc_i = $urandom;
        id_rs1_i = 5'($urandom_range(0, 7));
        id_rs2_i = 5'($urandom_range(0, 7));
        id_rd_i = 5'($urandom_range(0, 7));
        id_rs1_en_i = $urandom_range(0, 1) != 0;
        id_rs2_en_i = $urandom_range(0, 1) != 0;
        id_rd_we_i = $urandom_range(0, 1) != 0;
        ex_ready_i = $urandom_range(0, 3) != 0;
        flush_i = $urandom_range(0, 31) == 0;
        for (int p = 0; p < 4; p++) begin
            wb_we[p] = $urandom_range(0, 2) == 0;
            wb_addr[p] = 5'($urandom_range(0, 7));
            wb_data[p] = $urandom;
        end
    endtask

    initial begin
        logic [31:0] snap;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEADBEEF;
        rf[3] = 32'h55;
        rf[5] = 32'h11;
        rf[6] = 32'h22;
        mbusy = 0; m_valid = 0;
        idle();
        rst = 1;
        step();
        step();
        check("rst_valid", {31'b0, ex_valid_o}, 32'h0);
        check("rst_pc", ex_pc_o, 32'h0);
        check("rst_rs1", ex_rs1_data_o, 32'h0);
        check("rst_rs2", ex_rs2_data_o, 32'h0);
        check("rst_rd", {27'b0, ex_rd_o}, 32'h0);
        check("rst_rd_we", {31'b0, ex_rd_we_o}, 32'h0);
        check("rst_busy", dut.busy, 32'h0);
        rst = 0;

        // First instruction reads x5/x6 and claims x7.
        idle();
        id_valid_i = 1; id_pc_i = 32'h40;
        id_rs1_i = 5; id_rs1_en_i = 1; id_rs2_i = 6; id_rs2_en_i = 1;
        id_rd_i = 7; id_rd_we_i = 1;
        step();
        check("t1_valid", {31'b0, ex_valid_o}, 32'h1);
        check("t1_rs1", ex_rs1_data_o, 32'h11);
        check("t1_rs2", ex_rs2_data_o, 32'h22);
        check("t1_busy7", {31'b0, dut.busy[7]}, 32'h1);

        // Dependent consumer stalls until x7 retires.
        idle();
        id_valid_i = 1; id_pc_i = 32'h44; id_rs1_i = 7; id_rs1_en_i = 1;
        #1 check("raw_stall", {31'b0, id_ready_o}, 32'h0);
        step();
        wb_we[2] = 1; wb_addr[2] = 7; wb_data[2] = 32'hABCD;
        step();
        if (!BYP) begin
            wb_we[2] = 0;
            step();
        end
        check("raw_data", ex_rs1_data_o, 32'hABCD);
        check("raw_pc", ex_pc_o, 32'h44);

        // Jump beats int1 on the same register.
        idle();
        id_valid_i = 1; id_pc_i = 32'h48; id_rs2_i = 3; id_rs2_en_i = 1;
        wb_we[0] = 1; wb_addr[0] = 3; wb_data[0] = 32'h1;
        wb_we[3] = 1; wb_addr[3] = 3; wb_data[3] = 32'h2;
        step();
        check("prio_rs2", ex_rs2_data_o, BYP ? 32'h1 : 32'h55);
        if (!BYP) begin
            wb_we[0] = 0; wb_we[3] = 0;
            step();
            check("prio_rf", ex_rs2_data_o, 32'h1);
        end

        // Held output while execution backpressures.
        idle();
        id_valid_i = 1; id_pc_i = 32'h100; id_rs1_i = 5; id_rs1_en_i = 1;
        step();
        id_pc_i = 32'h200; ex_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check("hold_ready", {31'b0, id_ready_o}, 32'h0);
            step();
            check("hold_pc", ex_pc_o, 32'h100);
            check("hold_rs1", ex_rs1_data_o, 32'h11);
        end
        ex_ready_i = 1;
        step();
        check("hold_next", ex_pc_o, 32'h200);

        // x0 reads and writes are ignored.
        idle();
        id_valid_i = 1; id_pc_i = 32'h300;
        id_rs1_en_i = 1; id_rs2_en_i = 1; id_rd_we_i = 1;
        snap = mbusy;
        step();
        check("x0_rs1", ex_rs1_data_o, 32'h0);
        check("x0_rs2", ex_rs2_data_o, 32'h0);
        check("x0_busy", dut.busy, snap);

        // Flush drops the held op and the scoreboard.
        idle();
        id_valid_i = 1; id_pc_i = 32'h400; id_rd_i = 9; id_rd_we_i = 1;
        step();
        check("fl_busy9", {31'b0, dut.busy[9]}, 32'h1);
        flush_i = 1; ex_ready_i = 0;
        id_rd_we_i = 0; id_rs1_i = 9; id_rs1_en_i = 1;
        step();
        check("fl_valid", {31'b0, ex_valid_o}, 32'h0);
        check("fl_busy", dut.busy, 32'h0);
        flush_i = 0; ex_ready_i = 1; id_pc_i = 32'h404;
        #1 check("fl_ready", {31'b0, id_ready_o}, 32'h1);
        step();
        check("fl_accept", ex_pc_o, 32'h404);

        for (int i = 0; i < 3000; i++) begin
            rand_stim();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
